// File: rtl/rv32_pipe_ctrl.sv
// rv32 pipeline hazard controller.
// Stall/flush generation with a small freeze FSM.
module rv32_pipe_ctrl #(
  parameter int L2U_CYCLES   = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic        ex_redirect,
  input  logic        imem_ready,
  input  logic        dmem_busy,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        ex_mem_stall,
  output logic        l2u_active,
  output logic [15:0] hazard_cnt
);

  typedef enum logic [1:0] {
    RUN,
    L2U,
    FLUSH,
    MWAIT
  } state_t;

  localparam logic [1:0] L2U_INIT =
    (L2U_CYCLES > 1) ? 2'(L2U_CYCLES - 2) : 2'd0;
  localparam logic [1:0] FL_INIT =
    (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

  state_t      state, state_n;
  state_t      saved, saved_n;
  state_t      eff;
  logic [1:0]  cnt, cnt_n;
  logic [15:0] hazard_n;
  logic        l2u_hit;

  assign l2u_hit = ex_is_load & (ex_rd != 5'd0) &
                   ((id_use_rs1 & (id_rs1 == ex_rd)) |
                    (id_use_rs2 & (id_rs2 == ex_rd)));

  // Effective state: a finished MWAIT resumes the frozen window
  always_comb begin
    eff = state;
    if (state == MWAIT)
      eff = (cnt != 2'd0) ? saved : RUN;
  end

  // Next state, counters and stall/flush outputs
  always_comb begin
    state_n      = state;
    saved_n      = saved;
    cnt_n        = cnt;
    hazard_n     = hazard_cnt;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    l2u_active   = 1'b0;
    priority case (1'b1)
      dmem_busy: begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        state_n      = MWAIT;
        saved_n      = eff;
      end
      ex_redirect: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_n     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        cnt_n       = FL_INIT;
      end
      (eff == L2U): begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
        l2u_active  = 1'b1;
        state_n     = (cnt == 2'd0) ? RUN : L2U;
        cnt_n       = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
      end
      (eff == FLUSH): begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_n     = (cnt == 2'd0) ? RUN : FLUSH;
        cnt_n       = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
      end
      l2u_hit: begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
        l2u_active  = 1'b1;
        state_n     = (L2U_CYCLES > 1) ? L2U : RUN;
        cnt_n       = L2U_INIT;
        if (hazard_cnt != 16'hFFFF)
          hazard_n = hazard_cnt + 16'd1;
      end
      !imem_ready: begin
        pc_stall    = 1'b1;
        if_id_flush = 1'b1;
        state_n     = RUN;
      end
      default: begin
        state_n = RUN;
      end
    endcase
    if (if_id_flush)
      if_id_stall = 1'b0;
    if (!rst_n) begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_stall  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_stall = 1'b0;
      l2u_active   = 1'b0;
    end
  end

  // State, window counter and hazard counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      saved      <= RUN;
      cnt        <= 2'd0;
      hazard_cnt <= 16'd0;
    end else begin
      state      <= state_n;
      saved      <= saved_n;
      cnt        <= cnt_n;
      hazard_cnt <= hazard_n;
    end
  end

endmodule
